// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage and its prefetch FIFO.
package fetch_queue_unit_pkg;
  localparam int FQ_PC_BITS          = 8;
  localparam int FQ_INSTRUCTION_BITS = 16;
  localparam int FQ_QUEUE_DEPTH      = 4;
  localparam int FQ_RESET_PC         = 0;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} prefetch entries; flush empties it in one cycle.
module fetch_queue import fetch_queue_unit_pkg::*; #(
  parameter int WIDTH = FQ_PC_BITS + FQ_INSTRUCTION_BITS,
  parameter int DEPTH = FQ_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [cnt_bits(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC + one-outstanding BRAM read feeding a prefetch FIFO towards decode.
module fetch_queue_unit import fetch_queue_unit_pkg::*; #(
  parameter int PC_BITS          = FQ_PC_BITS,
  parameter int INSTRUCTION_BITS = FQ_INSTRUCTION_BITS,
  parameter int QUEUE_DEPTH      = FQ_QUEUE_DEPTH,
  parameter int RESET_PC         = FQ_RESET_PC
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_enable,
  input  logic                            i_redirect,
  input  logic [PC_BITS-1:0]              i_redirect_pc,
  input  logic                            i_prog_we,
  input  logic [PC_BITS-1:0]              i_prog_addr,
  input  logic [INSTRUCTION_BITS-1:0]     i_prog_data,
  input  logic                            i_ready,
  output logic                            o_valid,
  output logic [INSTRUCTION_BITS-1:0]     o_instruction,
  output logic [PC_BITS-1:0]              o_pc_next,
  output logic [cnt_bits(QUEUE_DEPTH)-1:0] o_count,
  output logic [PC_BITS-1:0]              o_fetch_pc
);
  localparam int CW = cnt_bits(QUEUE_DEPTH);
  localparam int EW = PC_BITS + INSTRUCTION_BITS;

  logic [INSTRUCTION_BITS-1:0] bram [2**PC_BITS];
  logic [INSTRUCTION_BITS-1:0] bram_q;
  logic [PC_BITS-1:0]          fetch_pc, rd_pc, bram_addr, head_pc;
  logic                        inflight, issue, push, pop;
  logic [CW-1:0]               count;
  logic [CW:0]                 committed;
  logic [EW-1:0]               head;

  // Program-load port shares the single BRAM address with fetch.
  assign bram_addr = i_prog_we ? i_prog_addr : fetch_pc;

  always_ff @(posedge clk) begin
    if (i_prog_we) bram[i_prog_addr] <= i_prog_data;
    bram_q <= bram[bram_addr];
  end

  // Slots already spoken for after this cycle's pop; the in-flight read holds one.
  assign pop       = o_valid & i_ready & ~i_redirect;
  assign committed = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = i_enable & ~i_prog_we & ~i_redirect &
                     (committed < (CW+1)'(QUEUE_DEPTH));
  assign push      = inflight & ~i_redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= PC_BITS'(RESET_PC);
      inflight <= 1'b0;
      rd_pc    <= '0;
    end else begin
      inflight <= issue;
      if (issue) rd_pc <= fetch_pc;
      if (i_redirect)  fetch_pc <= i_redirect_pc;
      else if (issue)  fetch_pc <= fetch_pc + 1'b1;
    end
  end

  fetch_queue #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rd_pc, bram_q}),
    .pop       (pop),
    .flush     (i_redirect),
    .count     (count),
    .head      (head)
  );

  assign head_pc       = head[EW-1 -: PC_BITS];
  assign o_valid       = (count != '0);
  assign o_instruction = o_valid ? head[INSTRUCTION_BITS-1:0] : '0;
  assign o_pc_next     = o_valid ? head_pc + 1'b1 : '0;
  assign o_count       = count;
  assign o_fetch_pc    = fetch_pc;
endmodule
